// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-requester round-robin arbiter for the data port of the
//             shared instruction/data RAM. Requester 0 is the core load/store
//             unit, requester 1 the debug/program loader. At most one access
//             is granted per cycle. A requester may lock the port for atomic
//             read-modify-write sequences; the lock is forcibly released
//             after LOCK_TIMEOUT consecutive owned cycles. Read data is
//             registered and returned one cycle after the grant.
//  Ports    : clock, reset        - clock, asynchronous active-high reset
//             m{0,1}_req/we/addr/wdata/lock - requester inputs
//             m{0,1}_gnt          - combinational accept
//             m{0,1}_rvalid/rdata - registered read response
//             lock_timeout        - one-cycle pulse on forced lock release
//             wEn, d_address, d_write_data, d_read_data - RAM data port
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  lock_timeout,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data
);

    localparam int         c_CNT_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_OWN0    = 2'd1;
    localparam logic [1:0] c_OWN1    = 2'd2;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(LOCK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_prio;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               w_owned;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_owned   = (r_state == c_OWN0) || (r_state == c_OWN1);
    // The owner has used up its allowance; the grant of this cycle still
    // completes but ownership ends at the coming edge.
    assign w_timeout = w_owned && (r_lock_cnt == c_CNT_MAX);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (m0_gnt && m0_lock) begin
                    w_next_state = c_OWN0;
                end else if (m1_gnt && m1_lock) begin
                    w_next_state = c_OWN1;
                end
            end
            c_OWN0: begin
                if (w_timeout || !m0_lock) begin
                    w_next_state = c_IDLE;
                end
            end
            c_OWN1: begin
                if (w_timeout || !m1_lock) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (grants and RAM drive)
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (m0_req && m1_req) begin
                    m0_gnt = ~r_prio;
                    m1_gnt = r_prio;
                end else begin
                    m0_gnt = m0_req;
                    m1_gnt = m1_req;
                end
            end
            // While locked the other requester is shut out even if the
            // owner is idle this cycle.
            c_OWN0:  m0_gnt = m0_req;
            c_OWN1:  m1_gnt = m1_req;
            default: ;
        endcase
        if (reset) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end

        if (m1_gnt) begin
            wEn          = m1_we;
            d_address    = m1_addr;
            d_write_data = m1_wdata;
        end else begin
            // Requester 0 also drives the address/data bus when idle.
            wEn          = m0_gnt & m0_we;
            d_address    = m0_addr;
            d_write_data = m0_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and lock counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio       <= 1'b0;
            r_lock_cnt   <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= w_timeout;
            if (r_state == c_IDLE) begin
                // Loser of this arbitration is favoured next time.
                if (m0_gnt || m1_gnt) begin
                    r_prio <= m0_gnt;
                end
            end else if (w_timeout) begin
                r_prio <= (r_state == c_OWN0);
            end

            if (r_state == c_IDLE && w_next_state != c_IDLE) begin
                r_lock_cnt <= c_CNT_ONE;
            end else if (w_owned && w_next_state == r_state) begin
                r_lock_cnt <= r_lock_cnt + c_CNT_ONE;
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data capture: one-cycle latency, rdata held until next read
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= d_read_data;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= d_read_data;
            end
        end
    end

endmodule
`default_nettype wire
